// File: rtl/gauss_dataflow_sched.sv
// gauss_dataflow_sched
// Start/done scheduler for the filtr_Gauss dataflow chain
// (AXIvideo2Mat -> rozmycie -> Mat2AXIvideo). Per-stage start-token counters
// turn the top-level ap_ctrl_hs handshake into per-process ap_start, and a
// small FSM implements a graceful stop/drain.
// Optional stall watchdog: define GAUSS_SCHED_STALL_MON_EN to build it.
module gauss_dataflow_sched #(
    parameter int PROC_NUM    = 3,
    parameter int TOKEN_DEPTH = 2,
    parameter int FRAME_CNT_W = 16,
    parameter int STALL_LIMIT = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ap_start,
    output logic                   ap_ready,
    output logic                   ap_done,
    output logic                   ap_idle,
    input  logic                   stop_req,
    output logic                   stopped,
    output logic [PROC_NUM-1:0]    proc_start,
    input  logic [PROC_NUM-1:0]    proc_ready,
    input  logic [PROC_NUM-1:0]    proc_done,
    input  logic [PROC_NUM-1:0]    proc_idle,
    output logic [FRAME_CNT_W-1:0] frames_done,
    output logic                   stall_detect,
    output logic [PROC_NUM-1:0]    stall_origin
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_STOPPED
    } state_t;

    localparam logic [3:0] TOK_MAX = 4'(TOKEN_DEPTH);

    state_t                 state_q, state_d;
    logic [3:0]             tok_q [1:PROC_NUM-1];
    logic [3:0]             tok_d [1:PROC_NUM-1];
    logic [7:0]             in_flight_q, in_flight_d;
    logic                   ap_done_q, ap_done_d;
    logic [FRAME_CNT_W-1:0] frames_q, frames_d;

    logic [PROC_NUM-1:0]    room;
    logic [PROC_NUM-1:0]    acc;
    logic                   launch_en;
    logic                   tok_empty_d;

    // Start generation: a stage may start only if it holds a token and the
    // next stage still has room to queue the token it will hand on.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned and a latch cannot be inferred.
        room       = '1;
        proc_start = '0;
        for (int i = 0; i < PROC_NUM - 1; i++) begin
            room[i] = (tok_q[i+1] < TOK_MAX);
        end
        launch_en     = (state_q == ST_RUN) || (state_q == ST_IDLE);
        proc_start[0] = launch_en & ap_start & room[0];
        for (int i = 1; i < PROC_NUM; i++) begin
            proc_start[i] = (tok_q[i] != 4'd0) & room[i];
        end
        acc = proc_start & proc_ready;
    end

    // Token, in-flight and frame bookkeeping for the next cycle.
    always_comb begin
        tok_empty_d = 1'b1;
        for (int i = 1; i < PROC_NUM; i++) begin
            tok_d[i] = tok_q[i] + {3'b000, acc[i-1]} - {3'b000, acc[i]};
            if (tok_d[i] != 4'd0) begin
                tok_empty_d = 1'b0;
            end
        end
        in_flight_d = in_flight_q + {7'd0, acc[0]} - {7'd0, ap_done_q};
        ap_done_d   = proc_done[PROC_NUM-1];
        frames_d    = frames_q + FRAME_CNT_W'(ap_done_q);
    end

    // Run/stop FSM: next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A frame accepted together with stop_req still has to finish.
                if (acc[0]) begin
                    state_d = stop_req ? ST_DRAIN : ST_RUN;
                end else if (stop_req) begin
                    state_d = ST_STOPPED;
                end
            end
            ST_RUN: begin
                if (stop_req) begin
                    state_d = ST_DRAIN;
                end else if (in_flight_d == 8'd0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if ((in_flight_d == 8'd0) && tok_empty_d) begin
                    state_d = ST_STOPPED;
                end
            end
            ST_STOPPED: begin
                if (!stop_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards every pending token and frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            in_flight_q <= '0;
            ap_done_q   <= 1'b0;
            frames_q    <= '0;
            for (int i = 1; i < PROC_NUM; i++) begin
                tok_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values regardless of statement order.
            state_q     <= state_d;
            in_flight_q <= in_flight_d;
            ap_done_q   <= ap_done_d;
            frames_q    <= frames_d;
            for (int i = 1; i < PROC_NUM; i++) begin
                tok_q[i] <= tok_d[i];
            end
        end
    end

    assign ap_ready    = acc[0];
    assign ap_done     = ap_done_q;
    assign stopped     = (state_q == ST_STOPPED);
    assign frames_done = frames_q;
    assign ap_idle     = (in_flight_q == 8'd0) & (&proc_idle) & ~(|proc_start);

`ifdef GAUSS_SCHED_STALL_MON_EN
    localparam int WD_W = $clog2(STALL_LIMIT + 1);

    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic                stall_q, stall_d;
    logic [PROC_NUM-1:0] origin_q, origin_d;

    // Watchdog: count cycles with frames in flight and no handshake at all;
    // the first trip latches which stages were waiting on a ready.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        stall_d  = stall_q;
        origin_d = origin_q;
        if ((|acc) || (|proc_done) || (in_flight_q == 8'd0)) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WD_W'(STALL_LIMIT)) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            if ((wd_cnt_d == WD_W'(STALL_LIMIT)) && !stall_q) begin
                stall_d  = 1'b1;
                origin_d = proc_start & ~proc_ready;
            end
        end
    end

    // Watchdog registers; the flags stay sticky until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt_q <= '0;
            stall_q  <= 1'b0;
            origin_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            stall_q  <= stall_d;
            origin_q <= origin_d;
        end
    end

    assign stall_detect = stall_q;
    assign stall_origin = origin_q;
`else
    assign stall_detect = 1'b0;
    assign stall_origin = '0;
`endif

endmodule
